ahb_sram_subordinate: RTL and testbench

//  AHB-Lite subordinate (responder) fronting a byte-addressable on-chip SRAM; the receiving end of
//  the htrans/hwrite/hready/hselx/hburst/haddr/hwdata traffic our AHB checkers watch. Decodes address

---
 rtl/ahb_pkg.sv | 39 +++
 rtl/ahb_sram_bank.sv | 35 +++
 rtl/ahb_sram_subordinate.sv | 174 +++++++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types, response codes and byte-lane helper for the SRAM subordinate.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAST,
        S_ERR1,
        S_ERR2
    } sub_state_e;

    // Little-endian byte enables for a legal (aligned, size <= word) transfer.
    function automatic logic [3:0] lane_enables(input logic [1:0] lane, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lane;
            2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-wide SRAM bank: synchronous byte-enabled write, registered read. Contents are never reset.
module ahb_sram_bank #(
    parameter int WORDS = 256,
    parameter int IDX_W = 8
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [3:0]       i_be,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [WORDS];
    logic [31:0] r_rdata;

    // A read on the same edge as a write to the same word returns the old contents; the top bypasses.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        if (i_re) begin
            r_rdata <= r_mem[i_ridx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of an on-chip SRAM: address decode, wait-state FSM,
// two-cycle ERROR responses, read-after-write bypass and a saturating error counter.
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0,
    parameter int ERRCNT_W    = 16
) (
    input  logic                i_clk,
    input  logic                i_resetn,
    input  logic                i_hsel,
    input  logic [ADDR_W-1:0]   i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [31:0]         i_hwdata,
    input  logic                i_hready,
    output logic                o_hreadyout,
    output logic                o_hresp,
    output logic [31:0]         o_hrdata,
    output logic [ERRCNT_W-1:0] o_err_cnt
);

    localparam int WORDS = MEM_BYTES / 4;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    sub_state_e          r_state;
    sub_state_e          w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [1:0]          r_lane;
    logic [1:0]          r_size;
    logic                r_write;
    logic [3:0]          r_wait_cnt;
    logic [3:0]          r_byp_mask;
    logic [31:0]         r_byp_data;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic                w_ready;
    logic                w_accept;
    logic                w_illegal;
    logic                w_misaligned;
    logic                w_we;
    logic                w_re;
    logic [3:0]          w_wr_be;
    logic [IDX_W-1:0]    w_idx;
    logic [31:0]         w_bank_rdata;
    logic                w_unused;

    assign w_unused = ^{i_hburst, i_htrans[0]};

    assign w_ready      = (r_state == S_IDLE) || (r_state == S_LAST) || (r_state == S_ERR2);
    assign w_accept     = w_ready && i_hsel && i_hready && i_htrans[1];
    assign w_idx        = i_haddr[IDX_W+1:2];
    assign w_misaligned = ((i_hsize == HSIZE_HALF) && i_haddr[0]) ||
                          ((i_hsize == HSIZE_WORD) && (i_haddr[1:0] != 2'b00));
    assign w_illegal    = ({1'b0, i_haddr} >= MEM_LIMIT) || (i_hsize > HSIZE_WORD) || w_misaligned;

    assign w_we    = (r_state == S_LAST) && r_write;
    assign w_re    = w_accept && !w_illegal && !i_hwrite;
    assign w_wr_be = lane_enables(r_lane, r_size);

    always_comb begin
        w_state_next = r_state;
        o_hreadyout  = 1'b1;
        o_hresp      = HRESP_OKAY;
        case (r_state)
            S_WAIT: begin
                o_hreadyout = 1'b0;
                if (r_wait_cnt == 4'd1) begin
                    w_state_next = S_LAST;
                end
            end
            S_ERR1: begin
                o_hreadyout  = 1'b0;
                o_hresp      = HRESP_ERROR;
                w_state_next = S_ERR2;
            end
            default: begin
                if (r_state == S_ERR2) begin
                    o_hresp = HRESP_ERROR;
                end
                if (!w_accept) begin
                    w_state_next = S_IDLE;
                end else if (w_illegal) begin
                    w_state_next = S_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_LAST;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Data-phase context is captured only on an accepted address phase.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_idx      <= '0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_write    <= 1'b0;
            r_wait_cnt <= 4'd0;
        end else begin
            if (w_accept) begin
                r_idx   <= w_idx;
                r_lane  <= i_haddr[1:0];
                r_size  <= i_hsize[1:0];
                r_write <= i_hwrite;
            end
            if (w_accept && !w_illegal) begin
                r_wait_cnt <= 4'(WAIT_STATES);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    // A read accepted while a write to the same word commits takes the written lanes from hwdata.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_byp_mask <= 4'b0000;
            r_byp_data <= 32'h0;
        end else if (w_re) begin
            r_byp_mask <= (w_we && (r_idx == w_idx)) ? w_wr_be : 4'b0000;
            r_byp_data <= i_hwdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_illegal && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    always_comb begin
        o_hrdata = 32'h0;
        if ((r_state == S_LAST) && !r_write) begin
            for (int b = 0; b < 4; b++) begin
                o_hrdata[8*b +: 8] = r_byp_mask[b] ? r_byp_data[8*b +: 8] : w_bank_rdata[8*b +: 8];
            end
        end
    end

    assign o_err_cnt = r_err_cnt;

    ahb_sram_bank #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_bank (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_be    (w_wr_be),
        .i_wdata (i_hwdata),
        .i_re    (w_re),
        .i_ridx  (w_idx),
        .o_rdata (w_bank_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Bench for ahb_sram_subordinate: one instance with no wait states and one with two, driven by a
// pipelined AHB manager and checked every cycle against a byte-array reference model.
module tb_ahb_sram_subordinate;
    import ahb_pkg::*;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [2:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        hsel0 = 1'b0;
    logic        hsel2 = 1'b0;
    logic [11:0] haddr = 12'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd0;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = 32'h0;
    logic        hready;
    logic        rdy0, rsp0, rdy2, rsp2;
    logic [31:0] rd0, rd2;
    logic [15:0] ec0, ec2;
    logic        curRdy, curResp;
    logic [31:0] curData;
    logic [15:0] curErr;
    bit          active = 1'b0;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  refMem [2][1024];
    int          refErr [2];
    xfer_t       txq [$];

    always #5 clk = ~clk;

    assign hready  = active ? rdy2 : rdy0;
    assign curRdy  = active ? rdy2 : rdy0;
    assign curResp = active ? rsp2 : rsp0;
    assign curData = active ? rd2 : rd0;
    assign curErr  = active ? ec2 : ec0;

    ahb_sram_subordinate #(.ADDR_W(12), .MEM_BYTES(1024), .WAIT_STATES(0), .ERRCNT_W(16)) dut0 (
        .i_clk(clk), .i_resetn(resetn), .i_hsel(hsel0), .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(rdy0), .o_hresp(rsp0), .o_hrdata(rd0), .o_err_cnt(ec0)
    );

    ahb_sram_subordinate #(.ADDR_W(12), .MEM_BYTES(1024), .WAIT_STATES(2), .ERRCNT_W(16)) dut2 (
        .i_clk(clk), .i_resetn(resetn), .i_hsel(hsel2), .i_haddr(haddr), .i_htrans(htrans),
        .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata), .i_hready(hready),
        .o_hreadyout(rdy2), .o_hresp(rsp2), .o_hrdata(rd2), .o_err_cnt(ec2)
    );

    function automatic xfer_t mkX(input bit sel, input logic [1:0] trans, input bit write,
                                  input logic [2:0] size, input logic [11:0] addr, input logic [31:0] wdata);
        xfer_t t;
        t.sel = sel; t.trans = trans; t.write = write; t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic bit isIllegal(input xfer_t t);
        if (t.addr >= 12'h400 || t.size > 3'd2) return 1'b1;
        return (int'(t.addr) % (1 << t.size)) != 0;
    endfunction

    function automatic logic [31:0] refWord(input logic [11:0] addr);
        int base;
        base = (int'(addr) / 4) * 4;
        return {refMem[active][base+3], refMem[active][base+2], refMem[active][base+1], refMem[active][base]};
    endfunction

    task automatic refWrite(input xfer_t t);
        for (int i = 0; i < (1 << t.size); i++) begin
            int a;
            a = int'(t.addr) + i;
            refMem[active][a] = t.wdata[8*(a%4) +: 8];
        end
    endtask

    function automatic xfer_t randX();
        xfer_t t;
        int r;
        t.sel = ($urandom_range(0, 99) < 92);
        r = $urandom_range(0, 9);
        t.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
        t.write = bit'($urandom_range(0, 1));
        r = $urandom_range(0, 19);
        t.size = (r < 18) ? 3'(r % 3) : 3'd3;
        if ($urandom_range(0, 15) == 0) begin
            t.addr = 12'h400 | 12'($urandom_range(0, 1023));
        end else begin
            t.addr = 12'($urandom_range(0, 127));
            if ($urandom_range(0, 7) != 0 && t.size <= 3'd2) begin
                t.addr = t.addr & ~12'((1 << t.size) - 1);
            end
        end
        t.wdata = $urandom();
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input xfer_t t);
        hsel0  = t.sel && !active;
        hsel2  = t.sel && active;
        haddr  = t.addr;
        htrans = t.trans;
        hwrite = t.write;
        hsize  = t.size;
        hburst = 3'($urandom_range(0, 7));
    endtask

    // Entered and left just after a rising edge; drains txq as a pipelined manager would.
    task automatic runQueue(input string tag);
        xfer_t       dp, nx;
        bit          dpValid;
        bit          done;
        int          k, guard, ws;
        logic        expRdy, expResp;
        logic [31:0] expData;
        dpValid = 1'b0; k = 0; guard = 0;
        ws = active ? 2 : 0;
        while ((txq.size() > 0 || dpValid) && guard < 1000) begin
            guard++;
            if (txq.size() > 0) applyStimulus(txq[0]);
            else applyStimulus(mkX(1'b0, 2'b00, 1'b0, 3'd0, 12'h0, 32'h0));
            hwdata = (dpValid && dp.write) ? dp.wdata : $urandom();
            @(negedge clk);
            expRdy = 1'b1; expResp = 1'b0; expData = 32'h0; done = 1'b1;
            if (dpValid) begin
                if (isIllegal(dp)) begin
                    expResp = 1'b1;
                    done    = (k == 1);
                end else begin
                    done = (k == ws);
                    if (done && !dp.write) expData = refWord(dp.addr);
                end
                expRdy = done;
            end
            checkOutput({tag, "_hreadyout"}, 32'(curRdy), 32'(expRdy));
            checkOutput({tag, "_hresp"}, 32'(curResp), 32'(expResp));
            checkOutput({tag, "_hrdata"}, curData, expData);
            @(posedge clk);
            if (dpValid) begin
                if (done) begin
                    if (!isIllegal(dp) && dp.write) refWrite(dp);
                    dpValid = 1'b0;
                end else begin
                    k++;
                end
            end
            if (done && txq.size() > 0) begin
                nx = txq.pop_front();
                if (nx.sel && nx.trans[1]) begin
                    dp = nx; dpValid = 1'b1; k = 0;
                    if (isIllegal(nx)) refErr[active]++;
                end
            end
            #1;
        end
        if (guard >= 1000) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL %s_drain: got timeout, expected queue drained", tag);
            txq.delete();
        end
        applyStimulus(mkX(1'b0, 2'b00, 1'b0, 3'd0, 12'h0, 32'h0));
        checkOutput({tag, "_err_cnt"}, 32'(curErr), 32'(refErr[active]));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] oldWord;
        refErr[0] = 0;
        refErr[1] = 0;
        $display("[TB] start");

        #2;
        checkOutput("reset_hreadyout0", 32'(rdy0), 32'd1);
        checkOutput("reset_hresp0", 32'(rsp0), 32'd0);
        checkOutput("reset_hrdata0", rd0, 32'h0);
        checkOutput("reset_err_cnt0", 32'(ec0), 32'd0);
        checkOutput("reset_hreadyout2", 32'(rdy2), 32'd1);
        checkOutput("reset_err_cnt2", 32'(ec2), 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // ---------------- zero wait-state instance ----------------
        active = 1'b0;
        for (int a = 0; a < 128; a += 4) txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'(a), $urandom()));
        runQueue("init0");

        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'h010, 32'h12345678));
        txq.push_back(mkX(1'b0, 2'b00, 1'b0, 3'd0, 12'h000, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h010, 32'h0));
        runQueue("ws0_rw");

        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'h020, 32'hA5A5A5A5));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h020, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd0, 12'h021, 32'h00003C00));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h020, 32'h0));
        runQueue("bypass0");

        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h400, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd1, 12'h003, 32'hFFFFFFFF));
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd3, 12'h010, 32'hFFFFFFFF));
        txq.push_back(mkX(1'b1, 2'b00, 1'b0, 3'd0, 12'h000, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h000, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h010, 32'h0));
        runQueue("illegal0");
        checkOutput("err_cnt_after_three_errors", 32'(ec0), 32'd3);

        d = $urandom();
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'h100, d));
        txq.push_back(mkX(1'b1, 2'b01, 1'b1, 3'd2, 12'h104, 32'h0));
        txq.push_back(mkX(1'b1, 2'b11, 1'b1, 3'd2, 12'h104, ~d));
        txq.push_back(mkX(1'b1, 2'b11, 1'b1, 3'd2, 12'h108, d ^ 32'h0F0F0F0F));
        txq.push_back(mkX(1'b1, 2'b11, 1'b1, 3'd2, 12'h10C, d + 32'd1));
        txq.push_back(mkX(1'b0, 2'b10, 1'b1, 3'd2, 12'h100, 32'hDEADBEEF));
        for (int a = 12'h100; a <= 12'h10C; a += 4) txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'(a), 32'h0));
        runQueue("burst0");

        for (int i = 0; i < 60; i++) txq.push_back(randX());
        for (int a = 0; a < 128; a += 4) txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'(a), 32'h0));
        runQueue("rand0");

        // ---------------- two wait-state instance ----------------
        active = 1'b1;
        for (int a = 0; a < 128; a += 4) txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'(a), $urandom()));
        runQueue("init2");

        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h004, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'h008, 32'hCAFEF00D));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h008, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b1, 3'd1, 12'h00A, 32'h77660000));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h008, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd1, 12'h402, 32'h0));
        runQueue("ws2_directed");

        for (int i = 0; i < 60; i++) txq.push_back(randX());
        for (int a = 0; a < 128; a += 4) txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'(a), 32'h0));
        runQueue("rand2");

        oldWord = refWord(12'h040);
        applyStimulus(mkX(1'b1, 2'b10, 1'b1, 3'd2, 12'h040, 32'h0));
        @(posedge clk); #1;
        applyStimulus(mkX(1'b0, 2'b00, 1'b0, 3'd0, 12'h0, 32'h0));
        hwdata = ~oldWord;
        @(negedge clk);
        checkOutput("rst_pre_wait_hreadyout", 32'(rdy2), 32'd0);
        #1 resetn = 1'b0;
        #1;
        checkOutput("rst_async_hreadyout", 32'(rdy2), 32'd1);
        checkOutput("rst_async_hresp", 32'(rsp2), 32'd0);
        checkOutput("rst_async_hrdata", rd2, 32'h0);
        checkOutput("rst_async_err_cnt2", 32'(ec2), 32'd0);
        checkOutput("rst_async_err_cnt0", 32'(ec0), 32'd0);
        refErr[0] = 0;
        refErr[1] = 0;
        @(posedge clk); @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h040, 32'h0));
        runQueue("rst_read2");

        active = 1'b0;
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h010, 32'h0));
        txq.push_back(mkX(1'b1, 2'b10, 1'b0, 3'd2, 12'h100, 32'h0));
        runQueue("post_rst0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
